// File: rtl/a2_bridge_pkg.sv
// Shared constants and state encoding for the
// Apple II bridge port scheduler.
package a2_bridge_pkg;

  localparam logic [2:0] BRIDGE_SEL_CTRL    = 3'd0;
  localparam logic [2:0] BRIDGE_SEL_DATA    = 3'd1;
  localparam logic [2:0] BRIDGE_SEL_ADDR_LO = 3'd2;
  localparam logic [2:0] BRIDGE_SEL_ADDR_HI = 3'd3;
  localparam logic [2:0] BRIDGE_SEL_M2      = 3'd4;
  localparam logic [2:0] BRIDGE_SEL_DIP     = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    RD_SETUP,
    RD_SAMPLE,
    WR_SETUP,
    WR_STROBE,
    WR_RELEASE
  } state_e;

endpackage

// File: rtl/a2_bridge_rr_pick.sv
// Requester 0 strict priority, others round-robin
// from the pointer, wrapping within 1..NUM_REQ-1.
module a2_bridge_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         valid,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant
);

  logic found;
  int   idx;

  // one-hot grant, first hit wins
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    if (valid[0]) begin
      grant[0] = 1'b1;
    end else begin
      for (int i = 0; i < NUM_REQ - 1; i++) begin
        idx = int'(ptr) + i;
        if (idx >= NUM_REQ) idx = idx - (NUM_REQ - 1);
        if (!found && valid[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/a2_bridge_scheduler.sv
// Arbitrates the multiplexed bridge port and runs
// fixed read/write sequences; samples sel 0 when idle.
module a2_bridge_scheduler
  import a2_bridge_pkg::*;
#(
  parameter int NUM_REQ            = 4,
  parameter int READ_SETUP_CYCLES  = 1,
  parameter int WRITE_PULSE_CYCLES = 1
) (
  input  logic                 clk_logic,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ-1:0]   req_write_i,
  input  logic [3*NUM_REQ-1:0] req_sel_i,
  input  logic [8*NUM_REQ-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [NUM_REQ-1:0]   rsp_valid_o,
  output logic [7:0]           rsp_rdata_o,
  output logic [7:0]           control_in_o,
  output logic                 control_strobe_o,
  output logic                 busy_o,
  output logic [2:0]           a2_bridge_sel_o,
  output logic                 a2_bridge_rd_n_o,
  output logic                 a2_bridge_wr_n_o,
  output logic [7:0]           a2_bridge_d_o,
  output logic                 a2_bridge_d_oe_o,
  input  logic [7:0]           a2_bridge_d_i
);

  localparam int PW = $clog2(NUM_REQ);

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gidx, gidx_q;
  logic [NUM_REQ-1:0] grant;
  logic [2:0]    sel_lat_q, op_sel, cur_sel;
  logic [7:0]    wdata_q, op_wdata, cur_wdata;
  logic          cur_wr, cur_idle, prev_idle_q;
  logic [2:0]    sel_d;
  logic          rd_n_d, wr_n_d, oe_d;
  logic [7:0]    d_o_d;

  a2_bridge_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid (req_valid_i),
    .ptr   (ptr_q),
    .grant (grant)
  );

  // grant index and the granted request's fields
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) gidx = PW'(i);
  end

  assign cur_sel   = req_sel_i[int'(gidx)*3 +: 3];
  assign cur_wdata = req_wdata_i[int'(gidx)*8 +: 8];
  assign cur_wr    = req_write_i[gidx];

  assign req_ready_o =
    (state_q == IDLE && !reset) ? grant : '0;
  assign busy_o = (state_q != IDLE);

  // port has been idle-driving (sel 0, rd_n low)
  assign cur_idle = (state_q == IDLE) &&
                    (a2_bridge_sel_o == BRIDGE_SEL_CTRL) &&
                    !a2_bridge_rd_n_o;

  // next state, phase counter and RR pointer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (|grant) begin
          state_d = cur_wr ? WR_SETUP : RD_SETUP;
          cnt_d   = 3'(READ_SETUP_CYCLES - 1);
          if (gidx != '0)
            ptr_d = (gidx == PW'(NUM_REQ - 1)) ?
                    PW'(1) : gidx + PW'(1);
        end
      end
      RD_SETUP: begin
        if (cnt_q == 3'd0) state_d = RD_SAMPLE;
        else cnt_d = cnt_q - 3'd1;
      end
      RD_SAMPLE: state_d = IDLE;
      WR_SETUP: begin
        state_d = WR_STROBE;
        cnt_d   = 3'(WRITE_PULSE_CYCLES - 1);
      end
      WR_STROBE: begin
        if (cnt_q == 3'd0) state_d = WR_RELEASE;
        else cnt_d = cnt_q - 3'd1;
      end
      WR_RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // bridge pin values for the state being entered
  always_comb begin
    op_sel   = (state_q == IDLE) ? cur_sel : sel_lat_q;
    op_wdata = (state_q == IDLE) ? cur_wdata : wdata_q;
    sel_d    = BRIDGE_SEL_CTRL;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    oe_d     = 1'b0;
    d_o_d    = a2_bridge_d_o;
    unique case (state_d)
      IDLE: rd_n_d = 1'b0;
      RD_SETUP: begin
        sel_d  = op_sel;
        rd_n_d = 1'b0;
      end
      WR_SETUP: begin
        sel_d = op_sel;
        d_o_d = op_wdata;
        oe_d  = 1'b1;
      end
      WR_STROBE: begin
        sel_d  = op_sel;
        d_o_d  = op_wdata;
        oe_d   = 1'b1;
        wr_n_d = 1'b0;
      end
      default: ;
    endcase
  end

  // state, latched request, registered pins, responses
  always_ff @(posedge clk_logic) begin
    if (reset) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      ptr_q            <= PW'(1);
      gidx_q           <= '0;
      sel_lat_q        <= '0;
      wdata_q          <= '0;
      a2_bridge_sel_o  <= BRIDGE_SEL_CTRL;
      a2_bridge_rd_n_o <= 1'b1;
      a2_bridge_wr_n_o <= 1'b1;
      a2_bridge_d_o    <= '0;
      a2_bridge_d_oe_o <= 1'b0;
      rsp_valid_o      <= '0;
      rsp_rdata_o      <= '0;
      control_in_o     <= 8'hFF;
      control_strobe_o <= 1'b0;
      prev_idle_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      ptr_q            <= ptr_d;
      a2_bridge_sel_o  <= sel_d;
      a2_bridge_rd_n_o <= rd_n_d;
      a2_bridge_wr_n_o <= wr_n_d;
      a2_bridge_d_o    <= d_o_d;
      a2_bridge_d_oe_o <= oe_d;
      if (state_q == IDLE && |grant) begin
        gidx_q    <= gidx;
        sel_lat_q <= cur_sel;
        wdata_q   <= cur_wdata;
      end
      if (state_q == RD_SETUP && state_d == RD_SAMPLE)
        rsp_rdata_o <= a2_bridge_d_i;
      rsp_valid_o <= '0;
      if (state_q == RD_SAMPLE || state_q == WR_RELEASE)
        rsp_valid_o <= NUM_REQ'(1) << gidx_q;
      prev_idle_q      <= cur_idle;
      control_strobe_o <= cur_idle && prev_idle_q;
      if (cur_idle && prev_idle_q)
        control_in_o <= a2_bridge_d_i;
    end
  end

endmodule
